// File: rtl/pid_pkg.sv
// pid_pkg: shared state encoding, accumulator sizing and saturation limits for the PID controller
package pid_pkg;
  typedef enum logic [2:0] {IDLE, MUL_P, MUL_I, MUL_D, UPD} state_e;
  function automatic int acc_w(input int dw, input int gw);
    return dw + gw + 6;
  endfunction
  function automatic logic signed [63:0] smax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] smin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/pid_if.sv
// pid_if: measurement handshake and controller result bus
interface pid_if #(
  parameter int DW = 16,
  parameter int UW = 20,
  parameter int STEP_W = 4
);
  logic                     meas_valid;
  logic                     meas_ready;
  logic [DW-1:0]            meas;
  logic                     out_valid;
  logic signed [UW-1:0]     u_out;
  logic signed [STEP_W-1:0] du_step;
  logic                     sat_hi;
  logic                     sat_lo;
  modport master (output meas_valid, meas, input meas_ready, out_valid, u_out, du_step, sat_hi, sat_lo);
  modport slave (input meas_valid, meas, output meas_ready, out_valid, u_out, du_step, sat_hi, sat_lo);
endinterface

// File: rtl/pid_mac.sv
// pid_mac: registered signed multiply-accumulate with load/accumulate select
module pid_mac #(
  parameter int AW = 9,
  parameter int BW = 19,
  parameter int ACC_W = 30
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic                    i_load,
  input  logic signed [AW-1:0]    i_a,
  input  logic signed [BW-1:0]    i_b,
  output logic signed [ACC_W-1:0] o_acc
);
  logic signed [AW+BW-1:0]  w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  r_acc;
  assign w_prod = i_a * i_b;
  assign w_prod_ext = {{(ACC_W-AW-BW){w_prod[AW+BW-1]}}, w_prod};
  assign o_acc = r_acc;
  // load the first product of a sample, add the following ones
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en) r_acc <= (i_load ? '0 : r_acc) + w_prod_ext;
endmodule

// File: rtl/pid_incr_ctrl.sv
// pid_incr_ctrl: velocity-form PID loop with periodic sample request and saturated actuator
module pid_incr_ctrl
  import pid_pkg::*;
#(
  parameter int DW = 16,
  parameter int GW = 8,
  parameter int FRAC = 4,
  parameter int UW = 20,
  parameter int STEP_W = 4,
  parameter int DIV = 20_000_000
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clear,
  input  logic [DW-1:0] target,
  input  logic [GW-1:0] kp,
  input  logic [GW-1:0] ki,
  input  logic [GW-1:0] kd,
  output logic          req_sample,
  pid_if.slave          bus
);
  localparam int ACC_W = acc_w(DW, GW);
  localparam int CW = $clog2(DIV);
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_MUL_P = MUL_P;
  localparam logic [2:0] S_MUL_I = MUL_I;
  localparam logic [2:0] S_MUL_D = MUL_D;
  localparam logic [2:0] S_UPD = UPD;
  localparam logic signed [63:0] U_MAX = smax(UW);
  localparam logic signed [63:0] U_MIN = smin(UW);
  localparam logic signed [63:0] S_MAX = smax(STEP_W);
  localparam logic signed [63:0] S_MIN = -S_MAX;
  logic [CW-1:0]            r_cnt;
  logic [2:0]               r_state;
  logic signed [DW:0]       r_e0, r_e1, r_e2;
  logic [GW-1:0]            r_kp, r_ki, r_kd;
  logic signed [UW-1:0]     r_u;
  logic signed [STEP_W-1:0] r_step;
  logic                     r_sat_hi, r_sat_lo, r_out_valid;
  logic                     w_accept, w_mac_en;
  logic [GW-1:0]            w_gain;
  logic signed [GW:0]       w_a;
  logic signed [DW+1:0]     w_d1;
  logic signed [DW+2:0]     w_d2, w_b;
  logic signed [ACC_W-1:0]  w_acc, w_du;
  logic signed [63:0]       w_du64, w_sum;
  logic signed [UW-1:0]     w_u_next;
  logic signed [STEP_W-1:0] w_step_next;
  assign req_sample = en && r_cnt == CW'(DIV - 1);
  assign bus.meas_ready = r_state == S_IDLE && en && !clear;
  assign bus.out_valid = r_out_valid;
  assign bus.u_out = r_u;
  assign bus.du_step = r_step;
  assign bus.sat_hi = r_sat_hi;
  assign bus.sat_lo = r_sat_lo;
  assign w_accept = bus.meas_valid && bus.meas_ready;
  assign w_mac_en = r_state == S_MUL_P || r_state == S_MUL_I || r_state == S_MUL_D;
  assign w_d1 = {r_e0[DW], r_e0} - {r_e1[DW], r_e1};
  assign w_d2 = {{2{r_e0[DW]}}, r_e0} - {r_e1[DW], r_e1, 1'b0} + {{2{r_e2[DW]}}, r_e2};
  assign w_gain = r_state == S_MUL_P ? r_kp : r_state == S_MUL_I ? r_ki : r_kd;
  assign w_a = {1'b0, w_gain};
  assign w_b = r_state == S_MUL_P ? {w_d1[DW+1], w_d1} : r_state == S_MUL_I ? {{2{r_e0[DW]}}, r_e0} : w_d2;
  assign w_du = w_acc >>> FRAC;
  assign w_du64 = {{(64-ACC_W){w_du[ACC_W-1]}}, w_du};
  assign w_sum = {{(64-UW){r_u[UW-1]}}, r_u} + w_du64;
  assign w_u_next = w_sum >= U_MAX ? U_MAX[UW-1:0] : w_sum <= U_MIN ? U_MIN[UW-1:0] : w_sum[UW-1:0];
  assign w_step_next = w_du64 > S_MAX ? S_MAX[STEP_W-1:0] : w_du64 < S_MIN ? S_MIN[STEP_W-1:0] : w_du64[STEP_W-1:0];
  pid_mac #(.AW(GW + 1), .BW(DW + 3), .ACC_W(ACC_W)) u_mac (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .i_clr  (clear),
    .i_en   (w_mac_en),
    .i_load (r_state == S_MUL_P),
    .i_a    (w_a),
    .i_b    (w_b),
    .o_acc  (w_acc)
  );
  // sample timer; restarts from zero whenever en drops
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (!en || r_cnt == CW'(DIV - 1)) ? '0 : r_cnt + CW'(1);
  // sequencer: accept, three MAC steps, update; states are numbered in visiting order
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else if (clear) r_state <= S_IDLE;
    else r_state <= r_state == S_IDLE ? (w_accept ? S_MUL_P : S_IDLE) : r_state == S_UPD ? S_IDLE : r_state + 3'd1;
  // snapshot error and gains on accept so later input changes cannot disturb the calculation
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      r_e0 <= '0;
      r_kp <= '0;
      r_ki <= '0;
      r_kd <= '0;
    end else if (w_accept) begin
      r_e0 <= {1'b0, target} - {1'b0, bus.meas};
      r_kp <= kp;
      r_ki <= ki;
      r_kd <= kd;
    end
  // results, history and saturation flags move only on UPD; clear drops everything in flight
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      r_e1 <= '0;
      r_e2 <= '0;
      r_u <= '0;
      r_step <= '0;
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      r_e1 <= '0;
      r_e2 <= '0;
      r_u <= '0;
      r_step <= '0;
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_state == S_UPD;
      if (r_state == S_UPD) begin
        r_e2 <= r_e1;
        r_e1 <= r_e0;
        r_u <= w_u_next;
        r_step <= w_step_next;
        r_sat_hi <= w_sum >= U_MAX;
        r_sat_lo <= w_sum <= U_MIN;
      end
    end
endmodule
